// File: rtl/div_unit_pkg.sv
// Shared divider definitions: FSM state codes, handshake levels, result bus layout
// and the EX opcodes that select DIV/DIVU.
package div_unit_pkg;

  localparam int unsigned RegWidth     = 32;
  localparam int unsigned DoubleRegBus = 2 * RegWidth;

  localparam logic [1:0] DivFree   = 2'b00;
  localparam logic [1:0] DivByZero = 2'b01;
  localparam logic [1:0] DivOn     = 2'b10;
  localparam logic [1:0] DivEnd    = 2'b11;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  // HI/LO write payload as EX sees it: hi = remainder, lo = quotient
  typedef struct packed {
    logic [RegWidth-1:0] rem;
    logic [RegWidth-1:0] quo;
  } div_result_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit and trial-subtract the divisor.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next_c,
  output logic             q_bit_c
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem < divisor always holds, so a set top bit of diff can only mean a borrow
  assign shifted    = {rem, dvd_bit};
  assign diff       = shifted - {1'b0, divisor};
  assign q_bit_c    = ~diff[WIDTH];
  assign rem_next_c = q_bit_c ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit for the EX stage: one quotient bit per clock,
// result held as {remainder, quotient} while ready_o is high.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int unsigned   CntW    = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH);

  logic [1:0]       state;
  logic [1:0]       next_state;
  logic [CntW-1:0]  cnt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH-1:0] abs1_c;
  logic [WIDTH-1:0] abs2_c;
  logic [WIDTH-1:0] quo_fix_c;
  logic [WIDTH-1:0] rem_fix_c;
  logic [WIDTH-1:0] rem_next_c;
  logic             q_bit_c;

  // Magnitudes for signed divides; 0x80000000 maps onto itself, which is exact unsigned
  assign abs1_c    = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign abs2_c    = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
  assign quo_fix_c = neg_q ? -quo : quo;
  assign rem_fix_c = neg_r ? -rem : rem;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem       (rem),
    .dvd_bit   (dvd[WIDTH-1]),
    .divisor   (dvs),
    .rem_next_c(rem_next_c),
    .q_bit_c   (q_bit_c)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= DivFree;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; annul_i takes priority everywhere
  always_comb begin
    next_state = state;
    case (state)
      DivFree: begin
        if (start_i == DivStart && !annul_i) begin
          next_state = (opdata2_i == '0) ? DivByZero : DivOn;
        end
      end
      DivByZero: begin
        next_state = annul_i ? DivFree : DivEnd;
      end
      DivOn: begin
        if (annul_i) begin
          next_state = DivFree;
        end else if (cnt == LastCnt) begin
          next_state = DivEnd;
        end
      end
      DivEnd: begin
        if (start_i == DivStop || annul_i) begin
          next_state = DivFree;
        end
      end
      default: next_state = DivFree;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      dvd      <= '0;
      dvs      <= '0;
      rem      <= '0;
      quo      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= '0;
      ready_o  <= DivResultNotReady;
    end else begin
      case (state)
        DivFree: begin
          ready_o  <= DivResultNotReady;
          result_o <= '0;
          if (next_state == DivOn) begin
            dvd   <= abs1_c;
            dvs   <= abs2_c;
            rem   <= '0;
            quo   <= '0;
            cnt   <= '0;
            neg_q <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            neg_r <= signed_div_i & opdata1_i[WIDTH-1];
          end
        end
        DivByZero: begin
          result_o <= '0;
        end
        DivOn: begin
          if (!annul_i) begin
            if (cnt != LastCnt) begin
              dvd <= {dvd[WIDTH-2:0], 1'b0};
              rem <= rem_next_c;
              quo <= {quo[WIDTH-2:0], q_bit_c};
              cnt <= cnt + CntW'(1);
            end else begin
              result_o <= {rem_fix_c, quo_fix_c};
            end
          end
        end
        DivEnd: begin
          if (next_state == DivFree) begin
            ready_o  <= DivResultNotReady;
            result_o <= '0;
          end else begin
            ready_o  <= DivResultReady;
          end
        end
        default: begin
          ready_o  <= DivResultNotReady;
          result_o <= '0;
        end
      endcase
    end
  end

endmodule
